// File: rtl/servo_slew_sequencer_if.sv
// Target handshake and duty/load outputs shared between the slew sequencer
// and whatever feeds it targets or consumes its PWM commands.
interface servo_slew_sequencer_if;
    logic [7:0] target;
    logic       target_valid;
    logic       target_ready;
    logic [7:0] duty;
    logic       load;
    logic       at_target;

    modport master (
        output target, target_valid,
        input  target_ready, duty, load, at_target
    );

    modport slave (
        input  target, target_valid,
        output target_ready, duty, load, at_target
    );
endinterface

// File: rtl/servo_slew_sequencer.sv
// Slews the PWM duty toward the latest accepted target by at most STEP counts
// per update frame, strobing load once per frame in which duty changes.
module servo_slew_sequencer #(
    parameter int         TICK_CYCLES = 1_000_000,
    parameter int         STEP        = 4,
    parameter logic [7:0] INIT_DUTY   = 8'h80
) (
    input  logic                          clock,
    input  logic                          reset,
    servo_slew_sequencer_if.slave         bus
);
    localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    localparam logic [1:0] SYNC = 2'd0;
    localparam logic [1:0] IDLE = 2'd1;
    localparam logic [1:0] RAMP = 2'd2;

    logic [CW-1:0] tick_count;
    logic          tick;
    logic [1:0]    state;
    logic [7:0]    duty;
    logic [7:0]    goal;
    logic          load;
    logic          target_ready;
    logic          at_target;
    logic          sync_pending;
    logic [8:0]    up_sum;
    logic [8:0]    down_diff;
    logic [7:0]    step_duty;

    assign tick = (tick_count == CW'(TICK_CYCLES - 1));

    // Next duty one frame closer to goal; the ninth bit catches overflow and
    // underflow so the result clamps to goal instead of wrapping.
    always_comb begin
        up_sum    = {1'b0, duty} + 9'(STEP);
        down_diff = {1'b0, duty} - 9'(STEP);
        step_duty = duty;
        if (duty < goal) begin
            step_duty = (up_sum >= {1'b0, goal}) ? goal : up_sum[7:0];
        end else if (duty > goal) begin
            step_duty = (down_diff[8] || (down_diff[7:0] <= goal)) ? goal : down_diff[7:0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tick_count   <= '0;
            state        <= SYNC;
            duty         <= INIT_DUTY;
            goal         <= INIT_DUTY;
            load         <= 1'b0;
            target_ready <= 1'b0;
            at_target    <= 1'b0;
            sync_pending <= 1'b1;
        end else begin
            tick_count   <= tick ? '0 : tick_count + CW'(1);
            load         <= 1'b0;
            target_ready <= 1'b1;
            at_target    <= (state == IDLE) && (duty == goal) && !sync_pending;

            // A transfer coinciding with a tick only affects the following frame.
            if (bus.target_valid && target_ready) begin
                goal <= bus.target;
            end

            case (state)
                SYNC: begin
                    if (tick) begin
                        load         <= 1'b1;
                        sync_pending <= 1'b0;
                        state        <= (duty == goal) ? IDLE : RAMP;
                    end
                end
                IDLE: begin
                    if (duty != goal) begin
                        state <= RAMP;
                    end
                end
                RAMP: begin
                    if (tick) begin
                        if (duty == goal) begin
                            state <= IDLE;
                        end else begin
                            duty <= step_duty;
                            load <= 1'b1;
                            if (step_duty == goal) begin
                                state <= IDLE;
                            end
                        end
                    end
                end
                default: state <= SYNC;
            endcase
        end
    end

    assign bus.duty         = duty;
    assign bus.load         = load;
    assign bus.target_ready = target_ready;
    assign bus.at_target    = at_target;
endmodule

// File: doc/servo_slew_sequencer.md
Name: servo_slew_sequencer

Overview:
- Upstream feeder for the PWM servo controller. Drives its 8-bit duty and one-cycle load strobe.
- Accepts a target position through a valid/ready handshake.
- Ramps the commanded duty toward the target by at most STEP counts per update frame, so the servo never jumps.
- Issues exactly one load pulse per frame in which duty changes, plus one initial sync load after reset.

Parameters:
- TICK_CYCLES, 1_000_000, clock cycles per update frame (20 ms at 50 MHz); legal range is 2 and up.
- STEP, 4, maximum duty change per frame; legal range 1..255.
- INIT_DUTY, 8'h80, duty value at reset (servo centre).

Ports:
- clock  in  1  system clock, 50 MHz, rising edge
- reset  in  1  asynchronous, active-high reset
- target  in  8  requested final duty
- target_valid  in  1  target is presented this cycle
- target_ready  out  1  block can accept a target this cycle
- duty  out  8  commanded duty to the PWM stage
- load  out  1  one-cycle strobe; the PWM stage latches duty on this cycle
- at_target  out  1  high when duty equals the current goal and no sync is pending

Behaviour:
- Reset (async, active-high) sets:
  - duty = INIT_DUTY, goal = INIT_DUTY
  - tick counter = 0, load = 0
  - target_ready = 0, at_target = 0
  - sync_pending = 1, state = SYNC
- Reset asserted mid-ramp abandons the ramp immediately; no further load is issued until the SYNC tick after release.
- Tick counter:
  - Counts 0..TICK_CYCLES-1 and wraps.
  - tick is internal and combinational, high when counter == TICK_CYCLES-1.
  - First tick occurs TICK_CYCLES cycles after reset release.
- Handshake:
  - target_ready = 1 in every cycle after reset release.
  - A transfer happens on a rising edge with target_valid && target_ready; goal <= target.
  - A newer target simply replaces goal. There is no queue; the latest accepted target wins.
- States:
  - SYNC:
    - On tick: load <= 1, duty unchanged (INIT_DUTY), sync_pending <= 0.
    - Then go to IDLE if duty == goal, else RAMP.
  - IDLE:
    - On any cycle with goal != duty, go to RAMP. No load is issued until the next tick.
    - at_target = 1 only here, and only when goal == duty.
  - RAMP, on tick:
    - If duty < goal: duty <= min(duty+STEP, goal).
    - If duty > goal: duty <= max(duty-STEP, goal).
    - load <= 1 in the same cycle duty updates; both are registered and change on the same edge.
    - If the new duty == goal, go to IDLE.
    - If on tick duty already equals goal (goal was changed back), issue no load and go to IDLE.
- Arithmetic:
  - Computed at 9-bit width and clamped, so duty never wraps past 8'hFF or below 8'h00.
- load:
  - High for exactly one cycle, at most once per frame, and never during reset.
  - load = 0 on ticks where duty is unchanged (except the SYNC tick).
- Simultaneous target transfer and tick in the same cycle:
  - The tick step uses the old goal.
  - The new goal takes effect from the next cycle and at the next tick.
- at_target:
  - Registered; equals (state == IDLE && duty == goal).
  - Drops the cycle after a differing target is accepted.

Test Plan:
- TICK_CYCLES=10, STEP=4. Release reset, no target -> duty=8'h80 throughout; a single load pulse at cycle 10; at_target=1 from cycle 11.
- Target 8'h90 accepted at cycle 12 -> loads at cycles 20, 30, 40, 50 with duty 8'h84, 8'h88, 8'h8C, 8'h90; at_target=1 after the 8'h90 load; no load at cycle 60.
- STEP=16, target 8'hFF from 8'hF8 -> one load with duty 8'hFF (clamped, no wrap). Then target 8'h02 from 8'h10 -> duty 8'h00 not reached, steps end exactly at 8'h02.
- Ramping up toward 8'hA0, new target 8'h80 presented in the same cycle as a tick at duty 8'h88 -> that tick gives duty 8'h8C (old goal); the following ticks give 8'h88, 8'h84, 8'h80; then IDLE.
- Reset asserted mid-ramp at duty 8'h94, held 3 cycles -> duty=8'h80, load=0, at_target=0 asynchronously; the next load is the SYNC pulse TICK_CYCLES cycles after release.
- Target equal to current duty (8'h80) in IDLE -> no load, at_target stays 1, target_ready stays 1.
